// File: rtl/operand_read_pkg.sv
// Shared register-bank definitions used by ID, EX, WB and the operand read stage.
// Holds default widths and the register-index type.
// No logic; types and constants only.
package operand_read_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NREG_DEF   = 16;
  // Address width must equal clog2(NREG) so every index selects a real register.
  localparam int AW_DEF     = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/operand_read_reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared by WB or flush.
// Latency: hazards are combinational from current pending state and same-cycle WB.
// No backpressure of its own; the top level combines hazards into out_ready.
module reg_scoreboard #(
  parameter int NREG = 16,
  parameter int AW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic          fl_en,
  input  logic [AW-1:0] fl_idx,
  input  logic          use_a,
  input  logic [AW-1:0] ra,
  input  logic          use_b,
  input  logic [AW-1:0] rb,
  input  logic          wrd,
  input  logic [AW-1:0] rd,
  output logic          haz_a,
  output logic          haz_b,
  output logic          haz_d
);

  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;

  // Clears first, then the issue set, so a same-cycle set on the same register wins.
  always_comb begin
    pend_nxt = pend;
    if (clr_en) pend_nxt[clr_idx] = 1'b0;
    if (fl_en)  pend_nxt[fl_idx]  = 1'b0;
    if (set_en) pend_nxt[set_idx] = 1'b1;
  end

  // Pending vector register.
  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= pend_nxt;
  end

  // A writeback landing this cycle resolves the hazard because its data is bypassed.
  always_comb begin
    haz_a = use_a & pend[ra] & ~(clr_en & (clr_idx == ra));
    haz_b = use_b & pend[rb] & ~(clr_en & (clr_idx == rb));
    haz_d = wrd   & pend[rd] & ~(clr_en & (clr_idx == rd));
  end

endmodule

// File: rtl/operand_read.sv
// Operand read stage: register array, WB bypass, pending scoreboard and one output slot to EX.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: out_ready drops while the slot is held by EX or a source/dest register is pending.
module operand_read
  import operand_read_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int AW     = AW_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              out_ready,
  input  logic [AW-1:0]     in_RA,
  input  logic [AW-1:0]     in_RB,
  input  logic              in_use_A,
  input  logic              in_use_B,
  input  logic [AW-1:0]     in_RD,
  input  logic              in_WRD,
  input  logic              in_flush,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              in_ready,
  output logic [DATA_W-1:0] out_A,
  output logic [DATA_W-1:0] out_B,
  output logic [AW-1:0]     out_RD,
  output logic              out_WRD
);

  logic [DATA_W-1:0] regs [NREG];

  logic haz_a, haz_b, haz_d;
  logic slot_free;
  logic accept;
  logic flush_clr;
  logic [DATA_W-1:0] opnd_a, opnd_b;

  reg_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
    .clk     (CLK),
    .rst     (RST),
    .set_en  (accept & in_WRD),
    .set_idx (in_RD),
    .clr_en  (wb_we),
    .clr_idx (wb_addr),
    .fl_en   (flush_clr),
    .fl_idx  (out_RD),
    .use_a   (in_use_A),
    .ra      (in_RA),
    .use_b   (in_use_B),
    .rb      (in_RB),
    .wrd     (in_WRD),
    .rd      (in_RD),
    .haz_a   (haz_a),
    .haz_b   (haz_b),
    .haz_d   (haz_d)
  );

  // Handshake: ready is independent of in_valid to avoid a combinational loop with ID.
  always_comb begin
    slot_free = ~out_valid | in_ready | in_flush;
    out_ready = slot_free & ~haz_a & ~haz_b & ~haz_d;
    accept    = in_valid & out_ready;
    // A flushed slot never reaches WB, so its destination must be released here.
    flush_clr = out_valid & in_flush & out_WRD;
  end

  // Operand select: same-cycle WB data beats the array; unused sources read as zero.
  always_comb begin
    opnd_a = '0;
    opnd_b = '0;
    if (in_use_A) opnd_a = (wb_we && wb_addr == in_RA) ? wb_data : regs[in_RA];
    if (in_use_B) opnd_b = (wb_we && wb_addr == in_RB) ? wb_data : regs[in_RB];
  end

  // Register array write port; R0 is an ordinary register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Output slot: load on accept, empty on consume or flush, otherwise hold.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid <= 1'b0;
      out_A     <= '0;
      out_B     <= '0;
      out_RD    <= '0;
      out_WRD   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_A     <= opnd_a;
      out_B     <= opnd_b;
      out_RD    <= in_RD;
      out_WRD   <= in_WRD;
    end else if (out_valid && (in_ready || in_flush)) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_read.sv
// Directed bench for operand_read with a queue scoreboard and a decoupled output monitor.
// Latency: checks slot contents one cycle after each accept.
// Backpressure: exercises hazard stalls, EX hold, flush and reset.
module tb_operand_read;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid, out_ready;
  logic [3:0]  in_RA, in_RB, in_RD;
  logic        in_use_A, in_use_B, in_WRD, in_flush;
  logic        wb_we;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid, in_ready;
  logic [31:0] out_A, out_B;
  logic [3:0]  out_RD;
  logic        out_WRD;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  rd;
    logic        wrd;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  operand_read dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .out_ready(out_ready),
    .in_RA(in_RA), .in_RB(in_RB), .in_use_A(in_use_A), .in_use_B(in_use_B),
    .in_RD(in_RD), .in_WRD(in_WRD), .in_flush(in_flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .in_ready(in_ready),
    .out_A(out_A), .out_B(out_B), .out_RD(out_RD), .out_WRD(out_WRD)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic neg();
    @(negedge CLK);
  endtask

  task automatic idle();
    in_valid = 0; in_use_A = 0; in_use_B = 0; in_WRD = 0; in_flush = 0;
    in_RA = 0; in_RB = 0; in_RD = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic instr(input logic [3:0] ra, input logic ua, input logic [3:0] rb,
                       input logic ub, input logic [3:0] rd, input logic wrd);
    in_valid = 1; in_RA = ra; in_use_A = ua; in_RB = rb; in_use_B = ub;
    in_RD = rd; in_WRD = wrd;
  endtask

  task automatic wb(input logic [3:0] a, input logic [31:0] d);
    wb_we = 1; wb_addr = a; wb_data = d;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] rd, input logic wrd);
    exp_t e;
    e.a = a; e.b = b; e.rd = rd; e.wrd = wrd;
    q.push_back(e);
  endtask

  // Monitor: flushed slots drop their expectation, consumed slots are compared.
  always @(negedge CLK) begin
    if (!RST && out_valid) begin
      if (in_flush) begin
        if (q.size() > 0) void'(q.pop_front());
      end else if (in_ready) begin
        n_chk++;
        if (q.size() == 0) begin
          $display("FAIL slot: unexpected output A=%h B=%h RD=%0d WRD=%0b", out_A, out_B, out_RD, out_WRD);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (out_A === e.a && out_B === e.b && out_RD === e.rd && out_WRD === e.wrd) n_pass++;
          else $display("FAIL slot: got A=%h B=%h RD=%0d WRD=%0b expected A=%h B=%h RD=%0d WRD=%0b",
                        out_A, out_B, out_RD, out_WRD, e.a, e.b, e.rd, e.wrd);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    RST = 1; in_ready = 1;
    tick(); tick();
    neg();
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_A", out_A, 0);
    chk("rst_B", out_B, 0);
    chk("rst_rd_wrd", {27'b0, out_RD, out_WRD}, 0);
    RST = 0;
    neg();
    chk("rst_ready", {31'b0, out_ready}, 1);

    // 1: plain read after reset
    tick();
    instr(3, 1, 4, 1, 0, 0); push(0, 0, 0, 0);
    neg(); chk("t1_ready", {31'b0, out_ready}, 1);
    tick(); idle(); neg(); tick();

    // preload non-pending registers
    wb(1, 32'h1111_1111); tick();
    wb(2, 32'h2222_2222); tick();
    // same-cycle bypass on A, array read on B
    wb(3, 32'h3333_3333); instr(3, 1, 1, 1, 0, 0); push(32'h3333_3333, 32'h1111_1111, 0, 0);
    neg(); chk("byp_ready", {31'b0, out_ready}, 1);
    tick(); idle(); tick();

    // 2: RAW hazard on R5 released by WB
    instr(0, 0, 0, 0, 5, 1); push(0, 0, 5, 1);
    tick();
    instr(5, 1, 0, 0, 0, 0);
    neg(); chk("t2_stall0", {31'b0, out_ready}, 0);
    tick(); neg(); chk("t2_stall1", {31'b0, out_ready}, 0);
    tick();
    wb(5, 32'hDEAD_BEEF); push(32'hDEAD_BEEF, 0, 0, 0);
    neg(); chk("t2_release", {31'b0, out_ready}, 1);
    tick();
    wb_we = 0; instr(5, 1, 2, 1, 0, 0); push(32'hDEAD_BEEF, 32'h2222_2222, 0, 0);
    neg(); chk("t2_pend_clr", {31'b0, out_ready}, 1);
    tick(); idle(); tick();

    // 3: EX holds slot for 3 cycles, then back-to-back
    in_ready = 0;
    instr(5, 1, 0, 1, 6, 0); push(32'hDEAD_BEEF, 0, 6, 0);
    tick();
    instr(1, 1, 2, 1, 8, 0);
    for (int i = 0; i < 3; i++) begin
      neg();
      chk("t3_hold_ready", {31'b0, out_ready}, 0);
      chk("t3_hold_A", out_A, 32'hDEAD_BEEF);
      chk("t3_hold_rd", {28'b0, out_RD}, 6);
      tick();
    end
    in_ready = 1; push(32'h1111_1111, 32'h2222_2222, 8, 0);
    neg(); chk("t3_resume", {31'b0, out_ready}, 1);
    tick();
    instr(2, 1, 1, 1, 10, 0); push(32'h2222_2222, 32'h1111_1111, 10, 0);
    neg();
    chk("t3_b2b_ready", {31'b0, out_ready}, 1);
    chk("t3_b2b_A", out_A, 32'h1111_1111);
    tick(); idle(); tick();

    // 4: WB clear and issue set on R7 in the same cycle -> set wins
    instr(0, 0, 0, 0, 7, 1); push(0, 0, 7, 1);
    tick(); idle(); tick();
    wb(7, 32'h7777_7777); instr(0, 0, 0, 0, 7, 1); push(0, 0, 7, 1);
    neg(); chk("t4_hazd_byp", {31'b0, out_ready}, 1);
    tick();
    wb_we = 0; instr(7, 1, 0, 0, 0, 0);
    neg(); chk("t4_set_wins", {31'b0, out_ready}, 0);
    tick();
    wb(7, 32'h7777_AAAA); push(32'h7777_AAAA, 0, 0, 0);
    neg(); chk("t4_release", {31'b0, out_ready}, 1);
    tick(); idle(); tick();

    // 5: flush a held slot that writes R2, then read R2
    in_ready = 0;
    instr(0, 0, 0, 0, 2, 1); push(0, 0, 2, 1);
    tick();
    instr(2, 1, 0, 0, 0, 0); in_flush = 1;
    neg(); chk("t5_stall", {31'b0, out_ready}, 0);
    tick();
    in_flush = 0;
    neg();
    chk("t5_flushed", {31'b0, out_valid}, 0);
    chk("t5_pend_clr", {31'b0, out_ready}, 1);
    push(32'h2222_2222, 0, 0, 0);
    tick(); idle(); in_ready = 1; neg(); tick();

    // flush with simultaneous accept loads the new instruction
    in_ready = 0;
    instr(0, 0, 0, 0, 11, 0); push(0, 0, 11, 0);
    tick();
    in_flush = 1; instr(1, 1, 0, 0, 12, 0);
    neg(); chk("t5_flush_acc", {31'b0, out_ready}, 1);
    push(32'h1111_1111, 0, 12, 0);
    tick();
    idle(); in_ready = 1;
    neg(); chk("t5_new_valid", {31'b0, out_valid}, 1);
    tick();

    // 6: reset with full slot, pending R9 and an active WB
    in_ready = 0;
    instr(0, 0, 0, 0, 9, 1); push(0, 0, 9, 1);
    tick();
    RST = 1; wb(9, 32'h9999_9999); instr(1, 1, 2, 1, 3, 1);
    tick();
    q.delete();
    RST = 0; idle();
    neg();
    chk("t6_valid", {31'b0, out_valid}, 0);
    chk("t6_A", out_A, 0);
    chk("t6_B", out_B, 0);
    chk("t6_rd_wrd", {27'b0, out_RD, out_WRD}, 0);
    tick();
    in_ready = 1; instr(9, 1, 1, 1, 0, 0); push(0, 0, 0, 0);
    neg(); chk("t6_pend_clr", {31'b0, out_ready}, 1);
    tick(); idle(); tick(); tick();

    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
